// File: rtl/dmem_port_arbiter.sv
// Shares the single data-RAM port between the CPU data port and a debug access port.
// Latency: CPU access is granted combinationally in the same cycle. A debug access goes to
//   the RAM the cycle after arbitration is won, and dbg_ack pulses one cycle after that.
// Backpressure: the CPU is stalled for exactly the one cycle the debug access owns the port,
//   and whenever clk_enable is low. dbg_req is held by the requester until dbg_ack.
//
// Ports:
//   clk, reset (async, active-low), clk_enable (freezes the arbiter and blocks RAM strobes)
//   cpu_address/cpu_read/cpu_write/cpu_writedata -> CPU data-side request
//   cpu_readdata, cpu_stall                      -> CPU data-side response
//   dbg_req/dbg_write/dbg_address/dbg_writedata  -> debug request (held until dbg_ack)
//   dbg_readdata, dbg_ack                        -> debug response (registered)
//   mem_address/mem_read/mem_write/mem_writedata -> data RAM request
//   mem_readdata                                 <- data RAM combinational read data
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,

  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [DATA_W-1:0] dbg_writedata,
  output logic [DATA_W-1:0] dbg_readdata,
  output logic              dbg_ack,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    ST_CPU = 2'd0,  // CPU owns the port
    ST_DBG = 2'd1,  // debug access is on the port this cycle
    ST_ACK = 2'd2   // debug completion pulse, CPU owns the port again
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       cpu_req;
  logic       streak_hit;

  assign cpu_req    = cpu_read | cpu_write;
  assign streak_hit = (cnt == STREAK_MAX);

  // The RAM read data is a plain pass-through; only the CPU samples it when it owns the port.
  assign cpu_readdata = mem_readdata;

  // ---------------------------------------------------------------------------
  // State register. clk_enable low freezes both the state and the streak count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CPU;
      cnt   <= 4'd0;
    end else if (clk_enable) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // The streak counter measures how many cycles in a row the CPU has been granted
  // while debug waited. Once it reaches MAX_STREAK the next decision goes to debug
  // even if the CPU is still requesting, so debug latency is bounded.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_CPU: begin
        if (dbg_req && (!cpu_req || streak_hit)) begin
          state_nxt = ST_DBG;
          cnt_nxt   = 4'd0;
        end else if (!dbg_req) begin
          cnt_nxt = 4'd0;
        end else if (cpu_req && !streak_hit) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_DBG: begin
        state_nxt = ST_ACK;
        cnt_nxt   = 4'd0;
      end
      ST_ACK: begin
        // No re-grant here: a dbg_req still high on return to ST_CPU is a new request
        // and has to win arbitration again.
        state_nxt = ST_CPU;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ST_CPU;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: port mux and stall, decoded from the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_address   = cpu_address;
    mem_read      = cpu_read;
    mem_write     = cpu_write;
    mem_writedata = cpu_writedata;
    cpu_stall     = 1'b0;

    if (state == ST_DBG) begin
      mem_address   = dbg_address;
      mem_read      = !dbg_write;
      mem_write     = dbg_write;
      mem_writedata = dbg_writedata;
      cpu_stall     = cpu_req;
    end

    // Frozen cycle: nothing reaches the RAM, so any CPU access must be retried.
    if (!clk_enable) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cpu_stall = cpu_req;
    end

    // A write presented while reset is asserted must not corrupt RAM contents.
    if (!reset) begin
      mem_write = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug response registers. dbg_ack mirrors entry into ST_ACK, so it is a clean
  // flop output and holds its value while clk_enable is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_readdata <= '0;
      dbg_ack      <= 1'b0;
    end else if (clk_enable) begin
      dbg_ack <= (state_nxt == ST_ACK);
      if ((state == ST_DBG) && !dbg_write) begin
        dbg_readdata <= mem_readdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sanity properties on the handshake.
  // ---------------------------------------------------------------------------
  a_cnt_bound : assert property (@(posedge clk) disable iff (!reset)
    cnt <= STREAK_MAX);

  a_ack_follows_dbg : assert property (@(posedge clk) disable iff (!reset)
    (clk_enable && (state == ST_DBG)) |=> dbg_ack);

  a_ack_one_cycle : assert property (@(posedge clk) disable iff (!reset)
    (clk_enable && dbg_ack) |=> !dbg_ack);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_write;
  logic [DW-1:0] cpu_writedata;
  logic [DW-1:0] cpu_readdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_write;
  logic [AW-1:0] dbg_address;
  logic [DW-1:0] dbg_writedata;
  logic [DW-1:0] dbg_readdata;
  logic          dbg_ack;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address),
    .dbg_writedata(dbg_writedata), .dbg_readdata(dbg_readdata), .dbg_ack(dbg_ack),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Data RAM: 64 words, combinational read, write on the clock edge.
  logic [DW-1:0] ram [64];
  logic          ram_ready = 1'b0;
  assign mem_readdata = ram[mem_address[7:2]];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA5A50000 + 32'(i) * 32'h111;
      ram_ready <= 1'b1;
    end else if (mem_write) begin
      ram[mem_address[7:2]] <= mem_writedata;
    end
  end

  // Everything observable at the port in one cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        stall;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] crd;
  } port_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  port_t       expq[$];
  logic [31:0] dbgq[$];
  chk_t        chkq[$];

  int vectors     = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------------------
  // Reference model: who owns the RAM port this cycle, and the RAM contents.
  // dbg_turn   : 0 = debug absent or waiting, 1 = debug is on the port, 2 = completion pulse
  // cpu_run    : cycles the CPU has been served back-to-back while debug was waiting
  // ---------------------------------------------------------------------------
  logic [31:0] ref_ram [64];
  int          dbg_turn;
  int          cpu_run;
  logic [31:0] dbg_result;
  port_t       last_e;
  logic        prev_en;

  // sampled DUT outputs for directed checks
  logic        s_stall, s_ack, s_mrd, s_mwr;
  logic [31:0] s_maddr, s_rdat;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chkq.push_back(c);
  endtask

  task automatic model_outputs(output port_t e);
    logic creq;
    creq = cpu_read | cpu_write;
    if (!reset) begin
      dbg_turn   = 0;
      cpu_run    = 0;
      dbg_result = '0;
      dbgq.delete();
    end
    if (dbg_turn == 1) begin
      e.addr  = dbg_address;
      e.rd    = !dbg_write;
      e.wr    = dbg_write;
      e.wd    = dbg_writedata;
      e.stall = creq;
    end else begin
      e.addr  = cpu_address;
      e.rd    = cpu_read;
      e.wr    = cpu_write;
      e.wd    = cpu_writedata;
      e.stall = 1'b0;
    end
    if (!clk_enable) begin
      e.rd    = 1'b0;
      e.wr    = 1'b0;
      e.stall = creq;
    end
    if (!reset) e.wr = 1'b0;
    e.ack  = (dbg_turn == 2);
    e.rdat = dbg_result;
    e.crd  = ref_ram[e.addr[7:2]];
  endtask

  task automatic model_edge();
    logic creq;
    creq = cpu_read | cpu_write;
    if (!reset || !clk_enable) return;
    if (dbg_turn == 1 && !dbg_write) dbg_result = ref_ram[dbg_address[7:2]];
    if (last_e.wr) ref_ram[last_e.addr[7:2]] = last_e.wd;
    if (dbg_turn == 0) begin
      if (dbg_req && (!creq || cpu_run == MAXS)) begin
        dbg_turn = 1;
        cpu_run  = 0;
      end else if (!dbg_req) begin
        cpu_run = 0;
      end else if (creq && cpu_run < MAXS) begin
        cpu_run = cpu_run + 1;
      end
    end else if (dbg_turn == 1) begin
      dbg_turn = 2;
      dbgq.push_back(dbg_result);
    end else begin
      dbg_turn = 0;
    end
  endtask

  // One clock cycle: inputs already applied just after the previous rising edge.
  task automatic run_cycle();
    port_t e;
    model_outputs(e);
    expq.push_back(e);
    last_e = e;
    #4;
    s_stall = cpu_stall;
    s_ack   = dbg_ack;
    s_mrd   = mem_read;
    s_mwr   = mem_write;
    s_maddr = mem_address;
    s_rdat  = dbg_readdata;
    @(posedge clk);
    model_edge();
    prev_en = clk_enable;
    #1;
  endtask

  task automatic dbg_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rdat);
    int n;
    dbg_req       = 1'b1;
    dbg_write     = wr;
    dbg_address   = a;
    dbg_writedata = d;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!s_ack && n < 20);
    check("dbg_access_ack", 32'(s_ack), 32'd1);
    rdat    = s_rdat;
    dbg_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected port record per cycle, one expected read result per
  // accepted completion pulse, and any queued directed checks.
  // ---------------------------------------------------------------------------
  initial begin
    port_t       e;
    port_t       act;
    chk_t        c;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {mem_address, mem_read, mem_write, mem_writedata, cpu_stall, dbg_ack,
               dbg_readdata, cpu_readdata};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL port_cycle t=%0t: got addr=%h rd=%b wr=%b wd=%h stall=%b ack=%b rdat=%h crd=%h required addr=%h rd=%b wr=%b wd=%h stall=%b ack=%b rdat=%h crd=%h",
                   $time, act.addr, act.rd, act.wr, act.wd, act.stall, act.ack, act.rdat, act.crd,
                   e.addr, e.rd, e.wr, e.wd, e.stall, e.ack, e.rdat, e.crd);
        end
      end
      if (reset && clk_enable && dbg_ack) begin
        vectors++;
        if (dbgq.size() == 0) begin
          miscompares++;
          $display("FAIL dbg_completion t=%0t: got ack with readdata=%h required no ack", $time, dbg_readdata);
        end else begin
          x = dbgq.pop_front();
          if (dbg_readdata !== x) begin
            miscompares++;
            $display("FAIL dbg_completion t=%0t: got readdata=%h required %h", $time, dbg_readdata, x);
          end
        end
      end
      while (chkq.size() > 0) begin
        c = chkq.pop_front();
        vectors++;
        if (c.act !== c.exp) begin
          miscompares++;
          $display("FAIL %s t=%0t: got %h required %h", c.name, $time, c.act, c.exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          granted, nw108, nw10c, n, rst_left;
    logic [31:0] rd;

    for (int i = 0; i < 64; i++) ref_ram[i] = 32'hA5A50000 + 32'(i) * 32'h111;
    dbg_turn = 0; cpu_run = 0; dbg_result = '0; prev_en = 1'b1; last_e = '0;
    reset = 1'b0; clk_enable = 1'b1;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
    dbg_req = 1'b0; dbg_write = 1'b0; dbg_address = '0; dbg_writedata = '0;
    @(posedge clk);
    #1;

    // Reset state
    run_cycle();
    run_cycle();
    check("reset_ack", 32'(s_ack), 32'd0);
    check("reset_rdat", s_rdat, 32'd0);

    // CPU read right after reset release
    reset = 1'b1; cpu_read = 1'b1; cpu_address = 32'h100;
    run_cycle();
    check("cpu_read_addr", s_maddr, 32'h100);
    check("cpu_read_strobe", 32'(s_mrd), 32'd1);
    check("cpu_read_stall", 32'(s_stall), 32'd0);
    check("cpu_read_ack", 32'(s_ack), 32'd0);

    // Place a known word at 0x104 through the CPU port
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 32'h104; cpu_writedata = 32'hEEBF2468;
    run_cycle();
    cpu_write = 1'b0;

    // Debug read with the CPU idle, request held through the ack
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h104;
    run_cycle();
    check("idle_dbg_c0_read", 32'(s_mrd), 32'd0);
    run_cycle();
    check("idle_dbg_c1_read", 32'(s_mrd), 32'd1);
    check("idle_dbg_c1_addr", s_maddr, 32'h104);
    run_cycle();
    check("idle_dbg_c2_ack", 32'(s_ack), 32'd1);
    check("idle_dbg_c2_data", s_rdat, 32'hEEBF2468);
    run_cycle();
    check("idle_dbg_c3_ack", 32'(s_ack), 32'd0);
    check("idle_dbg_c3_read", 32'(s_mrd), 32'd0);
    run_cycle();
    check("idle_dbg_c4_ack", 32'(s_ack), 32'd0);
    check("idle_dbg_c4_read", 32'(s_mrd), 32'd1);
    run_cycle();
    check("idle_dbg_c5_ack", 32'(s_ack), 32'd1);
    dbg_req = 1'b0;
    run_cycle();

    // Continuous CPU reads against a held debug request
    cpu_read = 1'b1; cpu_address = 32'h180;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h104;
    granted = 0; n = 0;
    do begin
      run_cycle();
      n++;
      if (!s_stall && s_mrd && s_maddr == 32'h180) granted++;
    end while (!s_stall && n < 20);
    check("streak_granted", 32'(granted), 32'(MAXS + 1));
    check("streak_dbg_addr", s_maddr, 32'h104);
    run_cycle();
    check("streak_ack", 32'(s_ack), 32'd1);
    check("streak_ack_stall", 32'(s_stall), 32'd0);
    check("streak_cpu_addr_held", s_maddr, 32'h180);
    dbg_req = 1'b0; cpu_read = 1'b0;
    run_cycle();

    // Simultaneous CPU write and debug write
    cpu_write = 1'b1; cpu_address = 32'h10C; cpu_writedata = 32'hDEADBEEF;
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_address = 32'h108; dbg_writedata = 32'h12345678;
    nw108 = 0; nw10c = 0; n = 0;
    do begin
      run_cycle();
      n++;
      if (s_mwr && s_maddr == 32'h108) nw108++;
      if (s_mwr && s_maddr == 32'h10C) nw10c++;
      if (!s_stall) cpu_write = 1'b0;
    end while (!s_ack && n < 20);
    check("wr_dbg_cycles", 32'(nw108), 32'd1);
    check("wr_cpu_cycles", 32'(nw10c), 32'd1);
    dbg_req = 1'b0; cpu_write = 1'b0;
    run_cycle();
    dbg_access(1'b0, 32'h108, 32'h0, rd);
    check("readback_108", rd, 32'h12345678);
    run_cycle();
    dbg_access(1'b0, 32'h10C, 32'h0, rd);
    check("readback_10c", rd, 32'hDEADBEEF);
    run_cycle();

    // Reset during the debug cycle
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h104;
    run_cycle();
    reset = 1'b0; dbg_req = 1'b0;
    run_cycle();
    check("rst_dbg_read", 32'(s_mrd), 32'd0);
    check("rst_dbg_ack", 32'(s_ack), 32'd0);
    check("rst_dbg_rdat", s_rdat, 32'd0);
    run_cycle();
    reset = 1'b1; cpu_read = 1'b1; cpu_address = 32'h100;
    run_cycle();
    check("post_rst_read", 32'(s_mrd), 32'd1);
    check("post_rst_stall", 32'(s_stall), 32'd0);
    cpu_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("post_rst_no_ack", 32'(s_ack), 32'd0);
    end

    // Clock-enable freeze with the streak count at 2
    cpu_read = 1'b1; cpu_address = 32'h180;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h104;
    run_cycle();
    run_cycle();
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("freeze_strobes", 32'({s_mrd, s_mwr}), 32'd0);
      check("freeze_stall", 32'(s_stall), 32'd1);
    end
    clk_enable = 1'b1;
    granted = 0; n = 0;
    do begin
      run_cycle();
      n++;
      if (!s_stall && s_mrd && s_maddr == 32'h180) granted++;
    end while (!s_stall && n < 20);
    check("freeze_resume_granted", 32'(granted), 32'(MAXS - 1));
    run_cycle();
    check("freeze_ack", 32'(s_ack), 32'd1);
    dbg_req = 1'b0; cpu_read = 1'b0;
    run_cycle();

    // Randomised traffic
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_left > 0) begin
        reset = 1'b0;
        rst_left--;
      end else begin
        reset = 1'b1;
        if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 2);
      end
      clk_enable = ($urandom_range(0, 9) != 0);
      if (!last_e.stall) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
        case ($urandom_range(0, 3))
          2: cpu_read = 1'b1;
          3: cpu_write = 1'b1;
          default: ;
        endcase
        cpu_address   = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        cpu_writedata = $urandom;
      end
      if (!reset) begin
        dbg_req = 1'b0;
      end else begin
        if (dbg_req && last_e.ack && prev_en) dbg_req = 1'b0;
        if (!dbg_req && $urandom_range(0, 3) == 0) begin
          dbg_req       = 1'b1;
          dbg_write     = 1'($urandom_range(0, 1));
          dbg_address   = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          dbg_writedata = $urandom;
        end
      end
      run_cycle();
    end

    // Drain
    reset = 1'b1; clk_enable = 1'b1; dbg_req = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    check("dbg_queue_drained", 32'(dbgq.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
